// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply controller: state encoding,
// memory select codes, default matrix dimension and counter sizing.
package mm_pkg;

  localparam int N_DEF = 4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_A = 3'd1;
  localparam logic [2:0] S_RD_B = 3'd2;
  localparam logic [2:0] S_MAC  = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;

  // Width of the r/c/k counters; N is at least 2 so this is never zero.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mm_idx_cnt.sv
// Nested row/column/inner counters for mm_ctrl. inc_k steps k; inc_rc finishes
// an element (k cleared, c advanced, wrapping into r); clr restarts all three.
module mm_idx_cnt
  import mm_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = cnt_w(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc_k,
  input  logic          inc_rc,
  output logic [CW-1:0] r,
  output logic [CW-1:0] c,
  output logic [CW-1:0] k,
  output logic          last_k,
  output logic          last_elem
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r <= '0;
      c <= '0;
      k <= '0;
    end else if (clr) begin
      r <= '0;
      c <= '0;
      k <= '0;
    end else if (inc_rc) begin
      k <= '0;
      if (c == LAST) begin
        c <= '0;
        // Wrap r after the final element so it never leaves 0..N-1.
        r <= (r == LAST) ? '0 : r + 1'b1;
      end else begin
        c <= c + 1'b1;
      end
    end else if (inc_k) begin
      k <= k + 1'b1;
    end
  end

  assign last_k    = (k == LAST);
  assign last_elem = (r == LAST) && (c == LAST);

endmodule

// File: rtl/mm_ctrl.sv
// Moore controller sequencing C = A*B over a shared, grant-arbitrated memory.
// Optional build macro MM_CTRL_PERF_EN adds the 32-bit perf_cycles counter.
module mm_ctrl
  import mm_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          gnt,
  output logic [IW-1:0] i,
  output logic [IW-1:0] j,
  output logic [1:0]    sel,
  output logic          read,
  output logic          write,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          finish,
  output logic          busy
`ifdef MM_CTRL_PERF_EN
  ,
  output logic [31:0]   perf_cycles
`endif
);

  localparam int CW = cnt_w(N);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] r;
  logic [CW-1:0] c;
  logic [CW-1:0] k;
  logic          last_k;
  logic          last_elem;
  logic          start_ok;
  logic          inc_k;
  logic          inc_rc;

  assign start_ok = (state == S_IDLE) && start;
  assign inc_k    = (state == S_MAC) && !last_k;
  assign inc_rc   = (state == S_WR) && gnt;

  mm_idx_cnt #(
    .N  (N),
    .CW (CW)
  ) u_idx (
    .clk       (clk),
    .reset     (reset),
    .clr       (start_ok),
    .inc_k     (inc_k),
    .inc_rc    (inc_rc),
    .r         (r),
    .c         (c),
    .k         (k),
    .last_k    (last_k),
    .last_elem (last_elem)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RD_A;
      S_RD_A: if (gnt)   state_nxt = S_RD_B;
      S_RD_B: if (gnt)   state_nxt = S_MAC;
      S_MAC:  state_nxt = last_k ? S_WR : S_RD_A;
      S_WR:   if (gnt)   state_nxt = last_elem ? S_DONE : S_RD_A;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode only state and counters, so a stalled access holds by itself.
  always_comb begin
    i       = '0;
    j       = '0;
    sel     = SEL_A;
    read    = 1'b0;
    write   = 1'b0;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    finish  = 1'b0;
    case (state)
      S_RD_A: begin
        read    = 1'b1;
        i       = IW'(r);
        j       = IW'(k);
        sel     = SEL_A;
        mac_clr = (k == '0);
      end
      S_RD_B: begin
        read = 1'b1;
        i    = IW'(k);
        j    = IW'(c);
        sel  = SEL_B;
      end
      S_MAC:  mac_en = 1'b1;
      S_WR: begin
        write = 1'b1;
        i     = IW'(r);
        j     = IW'(c);
        sel   = SEL_C;
      end
      S_DONE: finish = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

`ifdef MM_CTRL_PERF_EN
  // Counts every non-IDLE cycle of the current run, DONE included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        perf_cycles <= '0;
    else if (start_ok) perf_cycles <= '0;
    else if (busy)     perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mm_ctrl.sv
// Scoreboard bench for mm_ctrl: two instances (N=2 and N=4), a reference
// access-sequence model, and a negedge monitor that pops and compares.
module tb_mm_ctrl;
  import mm_pkg::*;

  localparam int IW = 20;
  localparam logic [2:0] K_A = 3'd0, K_B = 3'd1, K_C = 3'd2, K_MAC = 3'd3, K_FIN = 3'd4;

  typedef struct packed {
    logic [2:0]    kind;
    logic [IW-1:0] i;
    logic [IW-1:0] j;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start_v [2];
  logic          gnt_v   [2];
  logic [IW-1:0] i_s     [2];
  logic [IW-1:0] j_s     [2];
  logic [1:0]    sel_s   [2];
  logic          rd_s    [2];
  logic          wr_s    [2];
  logic          clr_s   [2];
  logic          en_s    [2];
  logic          fin_s   [2];
  logic          busy_s  [2];
`ifdef MM_CTRL_PERF_EN
  logic [31:0]   perf_s  [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mm_ctrl #(.N(2 + 2 * g), .IW(IW)) u_dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start_v[g]),
      .gnt     (gnt_v[g]),
      .i       (i_s[g]),
      .j       (j_s[g]),
      .sel     (sel_s[g]),
      .read    (rd_s[g]),
      .write   (wr_s[g]),
      .mac_clr (clr_s[g]),
      .mac_en  (en_s[g]),
      .finish  (fin_s[g]),
      .busy    (busy_s[g])
`ifdef MM_CTRL_PERF_EN
      ,
      .perf_cycles (perf_s[g])
`endif
    );
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  ev_t q0[$];
  ev_t q1[$];

  bit            m_idle    [2] = '{1'b1, 1'b1};
  int            perf_m    [2] = '{0, 0};
  int            acc_cyc   [2] = '{0, 0};
  int            fin_cyc   [2] = '{0, 0};
  int            acc_cnt   [2] = '{0, 0};
  int            fin_cnt   [2] = '{0, 0};
  int            abort_cnt [2] = '{0, 0};
  int            wr_run    [2] = '{0, 0};
  int            acc_obs   [2] = '{0, 0};
  bit            pend      [2] = '{1'b0, 1'b0};
  logic          prd       [2];
  logic          pwr       [2];
  logic [IW-1:0] pi        [2];
  logic [IW-1:0] pj        [2];
  logic [1:0]    psel      [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: got 0x%0h, expected nothing (t=%0t)", name, act, $time);
  endtask

  function automatic int nn(input int d);
    return 2 + 2 * d;
  endfunction

  function automatic ev_t mk(input logic [2:0] kind, input int a, input int b);
    ev_t e;
    e.kind = kind;
    e.i    = IW'(a);
    e.j    = IW'(b);
    return e;
  endfunction

  function automatic void push_ev(input int d, input ev_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic ev_t qpop(input int d);
    return (d == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  function automatic void qflush(input int d);
    if (d == 0) q0.delete();
    else        q1.delete();
  endfunction

  // Reference: C[r][c] = sum_k A[r][k]*B[k][c], one element after another.
  function automatic void push_run(input int d);
    int n = nn(d);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        for (int k = 0; k < n; k++) begin
          push_ev(d, mk(K_A, r, k));
          push_ev(d, mk(K_B, k, c));
          push_ev(d, mk(K_MAC, 0, 0));
        end
        push_ev(d, mk(K_C, r, c));
      end
    push_ev(d, mk(K_FIN, 0, 0));
  endfunction

  task automatic observe(input int d, input ev_t e);
    ev_t x;
    if (qsize(d) == 0) begin
      fail("unexpected_event", 64'(e));
      return;
    end
    x = qpop(d);
    check("event", 64'(e), 64'(x));
    if (x.kind == K_A) check("mac_clr_k0", 64'(clr_s[d]), 64'(x.j == '0));
    if (e.kind == K_FIN) begin
      fin_cnt[d]++;
      fin_cyc[d] = cyc;
      check("writes_per_run", 64'(wr_run[d]), 64'(nn(d) * nn(d)));
      m_idle[d] = 1'b1;
    end
  endtask

  task automatic mon(input int d);
    ev_t e;
    if (!reset) begin
      check("reset_outs", {15'd0, i_s[d], j_s[d], sel_s[d], rd_s[d], wr_s[d],
                           clr_s[d], en_s[d], fin_s[d], busy_s[d]}, 64'd0);
`ifdef MM_CTRL_PERF_EN
      check("reset_perf", 64'(perf_s[d]), 64'd0);
`endif
      if (!m_idle[d]) abort_cnt[d]++;
      qflush(d);
      m_idle[d] = 1'b1;
      perf_m[d] = 0;
      wr_run[d] = 0;
      pend[d]   = 1'b0;
      return;
    end
`ifdef MM_CTRL_PERF_EN
    check("perf_cycles", 64'(perf_s[d]), 64'(perf_m[d]));
`endif
    check("busy", 64'(busy_s[d]), 64'(!m_idle[d]));
    check("rw_exclusive", 64'(rd_s[d] & wr_s[d]), 64'd0);
    if (clr_s[d]) check("mac_clr_ctx", {61'd0, rd_s[d], sel_s[d] == SEL_A, j_s[d] == '0}, 64'd7);
    if (pend[d])
      check("stall_hold", {20'd0, prd[d], pwr[d], pi[d], pj[d], psel[d]},
                          {20'd0, rd_s[d], wr_s[d], i_s[d], j_s[d], sel_s[d]});
    pend[d] = (rd_s[d] | wr_s[d]) && !gnt_v[d];
    prd[d] = rd_s[d]; pwr[d] = wr_s[d]; pi[d] = i_s[d]; pj[d] = j_s[d]; psel[d] = sel_s[d];

    if (m_idle[d] && start_v[d]) begin
      push_run(d);
      m_idle[d]  = 1'b0;
      perf_m[d]  = 0;
      wr_run[d]  = 0;
      acc_cyc[d] = cyc;
      acc_cnt[d]++;
    end else if (!m_idle[d]) begin
      perf_m[d]++;
    end

    if (rd_s[d] && gnt_v[d]) begin
      acc_obs[d]++;
      e.kind = {1'b0, sel_s[d]};
      e.i = i_s[d];
      e.j = j_s[d];
      observe(d, e);
    end
    if (wr_s[d] && gnt_v[d]) begin
      acc_obs[d]++;
      wr_run[d]++;
      e.kind = (sel_s[d] == SEL_C) ? K_C : {1'b0, sel_s[d]};
      e.i = i_s[d];
      e.j = j_s[d];
      observe(d, e);
    end
    if (en_s[d])  observe(d, mk(K_MAC, 0, 0));
    if (fin_s[d]) observe(d, mk(K_FIN, 0, 0));
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon(d);
  end

  task automatic do_start(input int d);
    @(posedge clk); #1;
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget);
    int n = 0;
    while (!m_idle[d] && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (!m_idle[d]) fail("timeout_waiting_finish", 64'(d));
    @(posedge clk); #1;
  endtask

  task automatic rand_drive(input int d, input int cycles);
    for (int t = 0; t < cycles; t++) begin
      @(posedge clk); #1;
      gnt_v[d]   = ($urandom_range(0, 9) < 7);
      start_v[d] = (t == 0) || ($urandom_range(0, 24) == 0);
    end
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    gnt_v[d]   = 1'b1;
    wait_done(d, 1000);
  endtask

  initial begin
    int n;
    int snap;
    int fsnap;
    reset = 1'b0;
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    gnt_v[0]   = 1'b1; gnt_v[1]   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy0", 64'(busy_s[0]), 64'd0);
    check("reset_read1", 64'(rd_s[1]), 64'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // N=2, gnt held high: finish on cycle 29 counted from start.
    do_start(0);
    wait_done(0, 100);
    check("latency_n2", 64'(fin_cyc[0] - acc_cyc[0]), 64'd29);

    // N=2, three-cycle stall in the first RD_B.
    do_start(0);
    @(posedge clk); #1;
    gnt_v[0] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    gnt_v[0] = 1'b1;
    wait_done(0, 100);
    check("latency_n2_stall", 64'(fin_cyc[0] - acc_cyc[0]), 64'd32);

    // Start pulses while busy and during DONE must be ignored.
    fsnap = fin_cnt[0];
    do_start(0);
    repeat (4) do_start(0);
    while (cyc < acc_cyc[0] + 29) begin @(posedge clk); #1; end
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(0, 100);
    repeat (5) @(posedge clk);
    #1;
    check("one_finish_per_start", 64'(fin_cnt[0] - fsnap), 64'd1);

    // Reset during the WR of element (1,0).
    do_start(0);
    n = 0;
    while (!(wr_s[0] && i_s[0] == 1 && j_s[0] == 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) fail("timeout_waiting_wr10", 64'(n));
    reset = 1'b0;
    #1;
    check("abort_outs", {15'd0, i_s[0], j_s[0], sel_s[0], rd_s[0], wr_s[0],
                         clr_s[0], en_s[0], fin_s[0], busy_s[0]}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    snap = acc_obs[0];
    repeat (40) @(posedge clk);
    #1;
    check("no_access_after_reset", 64'(acc_obs[0] - snap), 64'd0);

    // N=4, gnt held high.
    do_start(1);
    wait_done(1, 400);
    check("latency_n4", 64'(fin_cyc[1] - acc_cyc[1]), 64'd209);
`ifdef MM_CTRL_PERF_EN
    check("perf_n4_209", 64'(perf_s[1]), 64'd209);
`endif

    // Random grant and start traffic on both instances at once.
    fork
      rand_drive(0, 500);
      rand_drive(1, 900);
    join

    for (int d = 0; d < 2; d++) begin
      check("queue_drained", 64'(qsize(d)), 64'd0);
      check("finishes_vs_starts", 64'(fin_cnt[d]), 64'(acc_cnt[d] - abort_cnt[d]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
